// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bus shared by the fetch port, the data port and the
// memory side of mem_arbiter. The master issues requests, the slave answers.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store.
// One transaction at a time; data has priority, but a streak counter forces a
// fetch grant after MAX_DATA_BURST data grants made while a fetch was waiting.
//
// state  | meaning
// IDLE   | no transaction outstanding, arbitration happens this cycle
// BUSY_I | fetch outstanding on the memory bus
// BUSY_D | data access outstanding on the memory bus
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  i,
  mem_arbiter_if.slave  d,
  mem_arbiter_if.master mem
);

  localparam int STREAK_BITS = ($clog2(MAX_DATA_BURST + 1) > 3) ? $clog2(MAX_DATA_BURST + 1) : 3;
  localparam logic [STREAK_BITS-1:0] STREAK_MAX = STREAK_BITS'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t                  state, state_nxt;
  logic [STREAK_BITS-1:0]  streak, streak_nxt;
  logic                    req_q, req_nxt;
  logic                    we_q, we_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
  logic                    grant_d, grant_i;

  // data wins unless a fetch is waiting and the data streak is exhausted
  assign grant_d = (state == IDLE) && d.req && (!i.req || (streak < STREAK_MAX));
  assign grant_i = (state == IDLE) && !grant_d && i.req;

  // state, streak and registered memory request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      streak  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      req_q   <= req_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  // next-state: grant from IDLE, hold the bus in BUSY until mem ack
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    req_nxt    = req_q;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
          req_nxt   = 1'b1;
          we_nxt    = d.we;
          addr_nxt  = d.addr;
          wdata_nxt = d.wdata;
          if (!i.req)
            streak_nxt = '0;
          else if (streak < STREAK_MAX)
            streak_nxt = streak + 1'b1;
        end else if (grant_i) begin
          state_nxt  = BUSY_I;
          req_nxt    = 1'b1;
          we_nxt     = 1'b0;
          addr_nxt   = i.addr;
          wdata_nxt  = '0;
          streak_nxt = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem.ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  // acks are combinational so the requester sees completion in the mem ack cycle
  assign i.ack   = mem.ack && (state == BUSY_I);
  assign d.ack   = mem.ack && (state == BUSY_D);
  assign i.rdata = mem.rdata;
  assign d.rdata = mem.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random requesters and a memory model
// with variable latency; a reference model predicts every grant, a monitor
// pops the predictions when the DUT presents a transaction or an ack.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) db ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mb ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clock (clock),
    .reset (reset),
    .i     (ib.slave),
    .d     (db.slave),
    .mem   (mb.master)
  );

  typedef struct {
    bit            is_i;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } dresp_t;

  txn_t          txn_q[$];
  logic [DW-1:0] f_q[$];
  dresp_t        d_q[$];
  byte           grant_log[$];
  logic [DW-1:0] ref_mem[64];
  logic [DW-1:0] dev_mem[64];

  int errors = 0;
  int checks = 0;

  task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_fetch_addr(logic [AW-1:0] a);
    return (a < 32'd8) || (a == 32'd16);
  endfunction

  // ---------------- reference model: predicts grants from the arbitration rule
  bit m_busy;
  bit m_pushed;
  int m_streak;

  always @(negedge clock) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_pushed = 1'b0;
      m_streak = 0;
      txn_q.delete();
    end else begin
      if (m_pushed) begin
        chk1("grant_issued", txn_q.size() == 0, 1'b1);
        txn_q.delete();
      end
      m_pushed = 1'b0;
      if (m_busy) begin
        if (mb.ack === 1'b1) m_busy = 1'b0;
      end else if (db.req && (!ib.req || m_streak < MAXB)) begin
        txn_q.push_back('{1'b0, db.we, db.addr, db.wdata});
        m_streak = ib.req ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
        m_busy   = 1'b1;
        m_pushed = 1'b1;
      end else if (ib.req) begin
        txn_q.push_back('{1'b1, 1'b0, ib.addr, 32'h0});
        m_streak = 0;
        m_busy   = 1'b1;
        m_pushed = 1'b1;
      end
    end
  end

  // ---------------- monitor: compares DUT bus activity against predictions
  txn_t cur;
  bit   cur_valid, prev_req, prev_done;

  always @(posedge clock) begin
    logic   exp_i, exp_d;
    dresp_t r;
    #2;
    if (reset) begin
      cur_valid = 1'b0;
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk1("req_drop_after_ack", mb.req, 1'b0);
      if (mb.req && !prev_req) begin
        grant_log.push_back(is_fetch_addr(mb.addr) ? 8'h49 : 8'h44);
        chk1("grant_expected", txn_q.size() != 0, 1'b1);
        if (txn_q.size() != 0) begin
          cur       = txn_q.pop_front();
          cur_valid = 1'b1;
          chk32("grant_addr", mb.addr, cur.addr);
          chk1("grant_we", mb.we, cur.we);
          chk32("grant_wdata", mb.wdata, cur.wdata);
        end else begin
          cur_valid = 1'b0;
        end
      end else if (mb.req && cur_valid) begin
        chk32("hold_addr", mb.addr, cur.addr);
        chk1("hold_we", mb.we, cur.we);
        chk32("hold_wdata", mb.wdata, cur.wdata);
      end
      exp_i = mb.req && mb.ack && cur_valid && cur.is_i;
      exp_d = mb.req && mb.ack && cur_valid && !cur.is_i;
      chk1("i_ack", ib.ack, exp_i);
      chk1("d_ack", db.ack, exp_d);
      if (ib.ack && exp_i) begin
        chk1("i_resp_expected", f_q.size() != 0, 1'b1);
        if (f_q.size() != 0) chk32("i_rdata", ib.rdata, f_q.pop_front());
      end
      if (db.ack && exp_d) begin
        chk1("d_resp_expected", d_q.size() != 0, 1'b1);
        if (d_q.size() != 0) begin
          r = d_q.pop_front();
          if (!r.we) chk32("d_rdata", db.rdata, r.data);
        end
      end
      prev_done = mb.req && mb.ack;
      prev_req  = mb.req;
      if (prev_done) cur_valid = 1'b0;
    end
  end

  // ---------------- stimulus: requesters and memory model
  bit i_busy, d_busy, auto_i, auto_d, ia_s, da_s, mem_active, force_ack, stray_en;
  int i_pct, d_pct, lat_fix, mem_cnt;

  task automatic issue_fetch(logic [AW-1:0] a);
    ib.req   = 1'b1;
    ib.addr  = a;
    ib.we    = 1'($urandom_range(0, 1));
    ib.wdata = $urandom();
    f_q.push_back(ref_mem[a[5:0]]);
    i_busy = 1'b1;
  endtask

  task automatic issue_data(logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
    db.req   = 1'b1;
    db.we    = we;
    db.addr  = a;
    db.wdata = wd;
    d_q.push_back('{we, ref_mem[a[5:0]]});
    if (we) ref_mem[a[5:0]] = wd;
    d_busy = 1'b1;
  endtask

  task automatic new_fetch();
    issue_fetch(32'($urandom_range(0, 7)));
  endtask

  task automatic new_data();
    issue_data(1'($urandom_range(0, 1)), 32'($urandom_range(8, 15)), $urandom());
  endtask

  task automatic step();
    @(negedge clock);
    ia_s = ib.ack;
    da_s = db.ack;
    @(posedge clock);
    #1;
    if (mb.req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        if (lat_fix >= 0) mem_cnt = lat_fix;
        else mem_cnt = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 3));
      end
      if (mem_cnt == 0) begin
        mb.ack     = 1'b1;
        mb.rdata   = mb.we ? $urandom() : dev_mem[mb.addr[5:0]];
        if (mb.we) dev_mem[mb.addr[5:0]] = mb.wdata;
        mem_active = 1'b0;
      end else begin
        mb.ack   = 1'b0;
        mb.rdata = $urandom();
        mem_cnt--;
      end
    end else begin
      mem_active = 1'b0;
      mb.ack     = force_ack || (stray_en && $urandom_range(0, 3) == 0);
      mb.rdata   = $urandom();
    end
    if (i_busy) begin
      if (ia_s) begin
        i_busy = 1'b0;
        ib.req = 1'b0;
        if (auto_i && $urandom_range(0, 99) < i_pct) new_fetch();
      end
    end else if (auto_i && $urandom_range(0, 99) < i_pct) new_fetch();
    if (d_busy) begin
      if (da_s) begin
        d_busy = 1'b0;
        db.req = 1'b0;
        if (auto_d && $urandom_range(0, 99) < d_pct) new_data();
      end
    end else if (auto_d && $urandom_range(0, 99) < d_pct) new_data();
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((i_busy || d_busy) && k < budget) begin
      step();
      k++;
    end
    chk1("drain_done", i_busy || d_busy, 1'b0);
  endtask

  initial begin
    string exp_order;
    int    k;
    for (int a = 0; a < 64; a++) begin
      ref_mem[a] = 32'hA5000000 ^ (32'(a) * 32'h01010101);
      dev_mem[a] = ref_mem[a];
    end
    ref_mem[16] = 32'hDEADBEEF;
    dev_mem[16] = 32'hDEADBEEF;
    ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.wdata = '0;
    db.req = 1'b0; db.we = 1'b0; db.addr = '0; db.wdata = '0;
    mb.ack = 1'b0; mb.rdata = '0;
    lat_fix = -1; i_pct = 0; d_pct = 0;

    repeat (2) @(posedge clock);
    #1;
    chk1("rst_mem_req", mb.req, 1'b0);
    chk1("rst_mem_we", mb.we, 1'b0);
    chk32("rst_mem_addr", mb.addr, 32'h0);
    chk32("rst_mem_wdata", mb.wdata, 32'h0);
    chk1("rst_i_ack", ib.ack, 1'b0);
    chk1("rst_d_ack", db.ack, 1'b0);
    #2 reset = 1'b0;

    // single fetch, memory acks in the third mem_req cycle
    step();
    lat_fix = 2;
    issue_fetch(32'h10);
    drain(50);

    // zero-wait store then a load of the same word
    lat_fix = 0;
    issue_data(1'b1, 32'h20, 32'h12345678);
    drain(50);
    issue_data(1'b0, 32'h20, 32'h0);
    drain(50);

    // both requesters saturated: data bursts of MAXB separated by one fetch
    lat_fix = -1;
    grant_log.delete();
    auto_i = 1'b1; auto_d = 1'b1; i_pct = 100; d_pct = 100;
    new_fetch();
    new_data();
    k = 0;
    while (grant_log.size() < 10 && k < 400) begin
      step();
      k++;
    end
    auto_i = 1'b0; auto_d = 1'b0;
    drain(200);
    exp_order = "DDDDIDDDDI";
    chk1("order_len", grant_log.size() >= 10, 1'b1);
    if (grant_log.size() >= 10)
      for (int g = 0; g < 10; g++)
        chk32("grant_order", 32'(grant_log[g]), 32'(exp_order[g]));

    // random traffic with random latency and stray memory acks
    stray_en = 1'b1;
    auto_i = 1'b1; auto_d = 1'b1; i_pct = 40; d_pct = 60;
    repeat (3000) step();
    auto_i = 1'b0; auto_d = 1'b0;
    drain(500);
    stray_en = 1'b0;
    repeat (2) step();

    // reset in the middle of a data access
    lat_fix = 1000;
    issue_data(1'b0, 32'd9, 32'h0);
    k = 0;
    while (!mb.req && k < 20) begin
      step();
      k++;
    end
    chk1("rst_setup_req", mb.req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rst_mid_mem_req", mb.req, 1'b0);
    chk32("rst_mid_mem_addr", mb.addr, 32'h0);
    chk1("rst_mid_d_ack", db.ack, 1'b0);
    db.req = 1'b0;
    d_busy = 1'b0;
    mem_active = 1'b0;
    d_q.delete();
    f_q.delete();
    @(posedge clock);
    #3 reset = 1'b0;
    force_ack = 1'b1;
    repeat (3) begin
      step();
      #1;
      chk1("late_ack_d_ack", db.ack, 1'b0);
      chk1("late_ack_i_ack", ib.ack, 1'b0);
      chk1("late_ack_no_req", mb.req, 1'b0);
    end
    force_ack = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port, word-addressed memory between the instruction-fetch path and the load/store path of the MIPS core. It sits between the core's fetch and data ports and a unified memory, and issues one memory transaction at a time with a registered request/acknowledge handshake. Data accesses have priority over fetches. A streak counter guarantees that fetches cannot be starved by back-to-back loads and stores.

## Interface
- ADDR_WIDTH, 32, word address width.
- DATA_WIDTH, 32, data word width.
- MAX_DATA_BURST, 4, max consecutive data grants while a fetch is pending (≥1).
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_ack  out  1  fetch complete, one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DATA_WIDTH  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  data complete, one-cycle pulse; d_rdata valid this cycle for loads.
- d_rdata  out  DATA_WIDTH  loaded word.
- mem_req  out  1  memory request (registered), held until mem_ack.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_ack  in  1  memory completion; may arrive in the first mem_req cycle or any later cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data access outstanding.
- In IDLE, the arbiter decides every cycle:
  - d_req=1 and (i_req=0 or streak<MAX_DATA_BURST): grant data and go to BUSY_D.
  - Otherwise, if i_req=1: grant fetch and go to BUSY_I.
  - Otherwise: stay in IDLE.
- On a grant, the next edge loads:
  - mem_req=1;
  - mem_addr from the granted address;
  - mem_we=d_we for data, 0 for fetch;
  - mem_wdata=d_wdata for data, 0 for fetch.
- Streak counter (3 bits minimum, saturating at MAX_DATA_BURST), updated on each grant:
  - Data grant with i_req=1: increment.
  - Data grant with i_req=0: clear to 0.
  - Fetch grant: clear to 0.
- In BUSY_x, mem_* are held constant until mem_ack=1.
- i_ack = mem_ack & (state==BUSY_I); d_ack = mem_ack & (state==BUSY_D). Both are combinational.
- i_rdata = d_rdata = mem_rdata, passed through; contents are meaningful only while the matching ack is high.
- On the edge where mem_ack=1 in BUSY_x: state goes to IDLE and mem_req goes to 0. mem_addr, mem_we and mem_wdata keep their values.
- mem_ack while in IDLE is ignored and produces no ack.
- Requester rule: after sampling its ack, a requester either drops req or presents a new request in the next cycle. A req still high in the cycle after ack counts as a new request.
- Fetches are always reads. Store data is never routed to i_rdata.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - state=IDLE, streak=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - i_ack=0, d_ack=0.
- Reset mid-transaction abandons it: no ack is produced, and a later mem_ack is ignored.
- Transaction timeline, request seen in IDLE at cycle n:
  - mem_req high from cycle n+1.
  - Memory acks at cycle m ≥ n+1; requester ack is in cycle m.
  - IDLE at m+1; next mem_req at m+2 at the earliest.
- Minimum transaction spacing is 2 cycles (grant cycle plus one busy cycle). The mem_req=0 gap between transactions is always at least 1 cycle.
- Simultaneous i_req and d_req with streak<MAX_DATA_BURST: data wins.
- Simultaneous requests with streak==MAX_DATA_BURST: fetch wins.
- A request arriving during BUSY_x waits; it is evaluated in the following IDLE cycle.

## Test plan
- Reset: assert reset mid BUSY_D with mem_req=1 -> mem_req=0 the same cycle; after release, mem_ack=1 produces no d_ack.
- Single fetch: i_req, i_addr=0x10 at cycle 0; mem_ack at cycle 3 with mem_rdata=0xDEADBEEF -> mem_req=1, mem_addr=0x10, mem_we=0 during cycles 1-3; i_ack=1 and i_rdata=0xDEADBEEF in cycle 3 only; mem_req=0 at cycle 4.
- Store: d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678, zero-wait memory (mem_ack=mem_req) -> mem_we=1 and mem_wdata=0x12345678 in cycle 1; d_ack in cycle 1; i_ack never asserts.
- Priority: i_req and d_req both raised at cycle 0 -> first grant is data (mem_addr=d_addr); fetch is granted in the next IDLE cycle.
- Anti-starvation (MAX_DATA_BURST=4): d_req held continuously with new addresses, i_req held -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- Late ack / stray ack: mem_ack pulses while in IDLE -> no i_ack/d_ack and no state change; mem_ack delayed 10 cycles -> all mem_* outputs stable throughout the wait.
